// File: rtl/pio_irq_servicer.sv
// -----------------------------------------------------------------------------
// pio_irq_servicer
//
// Avalon-MM master that owns one edge-capturing PIO slave. After reset it
// writes the interrupt mask (offset 2). Whenever the PIO raises its irq, it
// reads edge_capture (offset 3), clears it with a write-to-clear of all ones,
// and queues the masked, non-zero bitmap in a small event FIFO. Downstream
// logic drains that FIFO through a valid/ready port.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   cfg_mask, cfg_load       new irq mask and its one-cycle load strobe
//   ovf_clr                  clears the sticky overflow flag
//   m_address, m_chipselect,
//   m_write_n, m_writedata   PIO bus outputs (decoded from the state register)
//   m_readdata               PIO read data, valid the cycle after the address
//   pio_irq                  PIO interrupt request
//   ev_valid, ev_data,
//   ev_ready                 event stream (FIFO head)
//   overflow                 sticky: an event was dropped on a full FIFO
//   ev_count                 FIFO occupancy
// -----------------------------------------------------------------------------
module pio_irq_servicer #(
    parameter int               WIDTH      = 5,
    parameter int               FIFO_DEPTH = 4,
    parameter logic [WIDTH-1:0] MASK_INIT  = {WIDTH{1'b1}}
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [WIDTH-1:0]              cfg_mask,
    input  logic                          cfg_load,
    input  logic                          ovf_clr,
    output logic [1:0]                    m_address,
    output logic                          m_chipselect,
    output logic                          m_write_n,
    output logic [31:0]                   m_writedata,
    input  logic [31:0]                   m_readdata,
    input  logic                          pio_irq,
    output logic                          ev_valid,
    output logic [WIDTH-1:0]              ev_data,
    input  logic                          ev_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   ev_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic [1:0] {
        S_MASK = 2'd0,
        S_IDLE = 2'd1,
        S_RD   = 2'd2,
        S_CLR  = 2'd3
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   mask_r;
    logic               mask_pend_r;
    logic [WIDTH-1:0]   fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               overflow_r;

    logic [WIDTH-1:0]   cap_s;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               push_ok_s;
    logic               drop_s;

    // Capture filter uses the mask currently held, not any same-cycle load.
    assign cap_s     = m_readdata[WIDTH-1:0] & mask_r;
    assign push_s    = (state_r == S_CLR) && (cap_s != {WIDTH{1'b0}});
    assign pop_s     = (count_r != {CNT_W{1'b0}}) && ev_ready;
    assign full_s    = (count_r == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push_ok_s = push_s && (!full_s || pop_s);
    assign drop_s    = push_s && full_s && !pop_s;

    assign ev_valid  = (count_r != {CNT_W{1'b0}});
    assign ev_data   = fifo_mem_r[rd_ptr_r];
    assign ev_count  = count_r;
    assign overflow  = overflow_r;

    // Bus strobes are a pure decode of the state register; each access is one cycle.
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = 2'd0;
        m_writedata  = 32'h0000_0000;
        case (state_r)
            S_MASK: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_MASK;
                m_writedata  = {{(32-WIDTH){1'b0}}, mask_r};
            end
            S_RD: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b1;
                m_address    = ADDR_EDGE;
            end
            S_CLR: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_EDGE;
                m_writedata  = 32'hFFFF_FFFF;
            end
            S_IDLE: begin
                m_chipselect = 1'b0;
                m_write_n    = 1'b1;
                m_address    = 2'd0;
                m_writedata  = 32'h0000_0000;
            end
            default: begin
                m_chipselect = 1'b0;
                m_write_n    = 1'b1;
                m_address    = 2'd0;
                m_writedata  = 32'h0000_0000;
            end
        endcase
    end

    // Sequencer: mask write, idle, read edge_capture, clear edge_capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_MASK;
        end else begin
            case (state_r)
                S_MASK:  state_r <= S_IDLE;
                S_IDLE: begin
                    // Pending mask update wins over a waiting irq.
                    if (mask_pend_r) begin
                        state_r <= S_MASK;
                    end else if (pio_irq) begin
                        state_r <= S_RD;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RD:    state_r <= S_CLR;
                S_CLR:   state_r <= S_IDLE;
                default: state_r <= S_MASK;
            endcase
        end
    end

    // Mask register and pending flag; a new load outranks the clear in S_MASK
    // so a mask arriving during the write is still written afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r      <= MASK_INIT;
            mask_pend_r <= 1'b0;
        end else if (cfg_load) begin
            mask_r      <= cfg_mask;
            mask_pend_r <= 1'b1;
        end else if (state_r == S_MASK) begin
            mask_r      <= mask_r;
            mask_pend_r <= 1'b0;
        end else begin
            mask_r      <= mask_r;
            mask_pend_r <= mask_pend_r;
        end
    end

    // Event FIFO storage; reset flushes contents as well as pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            fifo_mem_r[wr_ptr_r] <= cap_s;
        end else begin
            fifo_mem_r[wr_ptr_r] <= fifo_mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers (wrap naturally, depth is a power of two) and occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as ovf_clr keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

endmodule

// File: tb/tb_pio_irq_servicer.sv
// -----------------------------------------------------------------------------
// tb_pio_irq_servicer
//
// Self-checking bench for pio_irq_servicer with a behavioural edge-capturing
// PIO slave (registered readdata, mask at offset 2, edge_capture at offset 3
// with write-to-clear). Directed sequences plus a table of mask/edge vectors.
// -----------------------------------------------------------------------------
module tb_pio_irq_servicer;

    localparam int W = 5;
    localparam int D = 4;

    logic          clk;
    logic          reset_n;
    logic [W-1:0]  cfg_mask;
    logic          cfg_load;
    logic          ovf_clr;
    logic [1:0]    m_address;
    logic          m_chipselect;
    logic          m_write_n;
    logic [31:0]   m_writedata;
    logic [31:0]   m_readdata;
    logic          pio_irq;
    logic          ev_valid;
    logic [W-1:0]  ev_data;
    logic          ev_ready;
    logic          overflow;
    logic [2:0]    ev_count;

    // PIO model state
    logic [W-1:0]  pio_ec;
    logic [W-1:0]  pio_mask;
    logic [W-1:0]  edge_in;

    int n_checks;
    int n_fail;

    pio_irq_servicer #(
        .WIDTH      (W),
        .FIFO_DEPTH (D),
        .MASK_INIT  (5'h1F)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cfg_mask     (cfg_mask),
        .cfg_load     (cfg_load),
        .ovf_clr      (ovf_clr),
        .m_address    (m_address),
        .m_chipselect (m_chipselect),
        .m_write_n    (m_write_n),
        .m_writedata  (m_writedata),
        .m_readdata   (m_readdata),
        .pio_irq      (pio_irq),
        .ev_valid     (ev_valid),
        .ev_data      (ev_data),
        .ev_ready     (ev_ready),
        .overflow     (overflow),
        .ev_count     (ev_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge-capturing PIO: clear write has priority over a coincident edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pio_ec     <= 5'd0;
            pio_mask   <= 5'd0;
            m_readdata <= 32'd0;
        end else begin
            if (m_chipselect && m_write_n && m_address == 2'd3) begin
                m_readdata <= {27'd0, pio_ec};
            end else if (m_chipselect && m_write_n && m_address == 2'd2) begin
                m_readdata <= {27'd0, pio_mask};
            end else begin
                m_readdata <= 32'd0;
            end
            if (m_chipselect && !m_write_n && m_address == 2'd2) begin
                pio_mask <= m_writedata[W-1:0];
            end
            if (m_chipselect && !m_write_n && m_address == 2'd3) begin
                pio_ec <= (pio_ec | edge_in) & ~m_writedata[W-1:0];
            end else begin
                pio_ec <= pio_ec | edge_in;
            end
        end
    end

    assign pio_irq = |(pio_ec & pio_mask);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input logic cs, input logic wn,
                             input logic [1:0] addr, input logic [31:0] wd);
        check({name, ".cs"},   {31'd0, m_chipselect}, {31'd0, cs});
        check({name, ".wn"},   {31'd0, m_write_n},    {31'd0, wn});
        check({name, ".addr"}, {30'd0, m_address},    {30'd0, addr});
        check({name, ".wd"},   m_writedata,           wd);
    endtask

    task automatic load_mask(input logic [W-1:0] m);
        cfg_mask = m;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        tick();
        tick();
        tick();
    endtask

    // One edge injection followed by enough cycles for read, clear and push.
    task automatic service(input logic [W-1:0] v);
        edge_in = v;
        tick();
        edge_in = 5'd0;
        tick();
        tick();
        tick();
        tick();
    endtask

    typedef struct {
        logic [W-1:0] mask;
        logic [W-1:0] edges;
        logic [W-1:0] exp;
    } vec_t;

    vec_t vecs[6];
    logic [W-1:0] drain_exp[4];

    initial begin
        vecs[0] = '{mask: 5'h1F, edges: 5'b00101, exp: 5'b00101};
        vecs[1] = '{mask: 5'h03, edges: 5'b00110, exp: 5'b00010};
        vecs[2] = '{mask: 5'h18, edges: 5'b11001, exp: 5'b11000};
        vecs[3] = '{mask: 5'h10, edges: 5'b10000, exp: 5'b10000};
        vecs[4] = '{mask: 5'h01, edges: 5'b11111, exp: 5'b00001};
        vecs[5] = '{mask: 5'h1F, edges: 5'b01010, exp: 5'b01010};

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        cfg_mask = 5'd0;
        cfg_load = 1'b0;
        ovf_clr  = 1'b0;
        ev_ready = 1'b0;
        edge_in  = 5'd0;

        // Reset release: first cycle writes MASK_INIT, then the bus idles.
        tick();
        tick();
        reset_n = 1'b1;
        check_bus("rst_maskwr", 1'b1, 1'b0, 2'd2, 32'h0000_001F);
        tick();
        check_bus("rst_idle", 1'b0, 1'b1, 2'd0, 32'h0);
        check("rst_ev_valid", {31'd0, ev_valid}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_ev_count", {29'd0, ev_count}, 32'd0);

        // Service latency; ev_ready held high so the empty-FIFO push is not popped.
        ev_ready = 1'b1;
        edge_in  = 5'b00101;
        tick();
        edge_in  = 5'd0;
        check_bus("lat_idle", 1'b0, 1'b1, 2'd0, 32'h0);
        tick();
        check_bus("lat_rd", 1'b1, 1'b1, 2'd3, 32'h0);
        tick();
        check_bus("lat_clr", 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
        check("lat_not_yet_valid", {31'd0, ev_valid}, 32'd0);
        tick();
        check("lat_ev_valid", {31'd0, ev_valid}, 32'd1);
        check("lat_ev_data", {27'd0, ev_data}, 32'h05);
        check("lat_ev_count", {29'd0, ev_count}, 32'd1);
        tick();
        check("lat_popped", {31'd0, ev_valid}, 32'd0);
        ev_ready = 1'b0;

        // cfg_load during S_RD narrows the filter for the capture in S_CLR.
        edge_in = 5'b00110;
        tick();
        edge_in = 5'd0;
        tick();
        check_bus("cfg_rd", 1'b1, 1'b1, 2'd3, 32'h0);
        cfg_mask = 5'b00001;
        cfg_load = 1'b1;
        tick();
        cfg_load = 1'b0;
        check_bus("cfg_clr", 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
        tick();
        check("cfg_no_push", {31'd0, ev_valid}, 32'd0);
        check_bus("cfg_idle", 1'b0, 1'b1, 2'd0, 32'h0);
        tick();
        check_bus("cfg_maskwr", 1'b1, 1'b0, 2'd2, 32'h0000_0001);
        tick();

        // Table of mask / edge vectors.
        for (int i = 0; i < 6; i++) begin
            load_mask(vecs[i].mask);
            service(vecs[i].edges);
            check($sformatf("vec%0d_valid", i), {31'd0, ev_valid}, 32'd1);
            check($sformatf("vec%0d_data", i), {27'd0, ev_data}, {27'd0, vecs[i].exp});
            ev_ready = 1'b1;
            tick();
            ev_ready = 1'b0;
            check($sformatf("vec%0d_drained", i), {29'd0, ev_count}, 32'd0);
        end

        // Overflow: five events into a four-entry FIFO with no consumer.
        load_mask(5'h1F);
        for (int i = 1; i <= 5; i++) begin
            service(5'(i));
        end
        check("ovf_count", {29'd0, ev_count}, 32'd4);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_head", {27'd0, ev_data}, 32'd1);
        ev_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("ovf_pop%0d", i), {27'd0, ev_data}, i);
            tick();
        end
        ev_ready = 1'b0;
        check("ovf_empty", {31'd0, ev_valid}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO with push and pop on the same edge.
        for (int i = 1; i <= 4; i++) begin
            service(5'(i));
        end
        edge_in = 5'b11000;
        tick();
        edge_in = 5'd0;
        tick();
        tick();
        check_bus("pp_clr", 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        check("pp_count", {29'd0, ev_count}, 32'd4);
        check("pp_overflow", {31'd0, overflow}, 32'd0);
        check("pp_head", {27'd0, ev_data}, 32'd2);
        drain_exp[0] = 5'd2;
        drain_exp[1] = 5'd3;
        drain_exp[2] = 5'd4;
        drain_exp[3] = 5'b11000;
        ev_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_drain%0d", i), {27'd0, ev_data}, {27'd0, drain_exp[i]});
            tick();
        end
        ev_ready = 1'b0;
        check("pp_empty", {31'd0, ev_valid}, 32'd0);

        // Reset asserted during S_CLR with two entries queued.
        service(5'd7);
        service(5'd9);
        check("rst2_pre_count", {29'd0, ev_count}, 32'd2);
        edge_in = 5'b00011;
        tick();
        edge_in = 5'd0;
        tick();
        tick();
        check_bus("rst2_clr", 1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF);
        reset_n = 1'b0;
        #1;
        check("rst2_ev_valid", {31'd0, ev_valid}, 32'd0);
        check("rst2_ev_count", {29'd0, ev_count}, 32'd0);
        tick();
        reset_n = 1'b1;
        check_bus("rst2_maskwr", 1'b1, 1'b0, 2'd2, 32'h0000_001F);
        tick();
        check_bus("rst2_idle", 1'b0, 1'b1, 2'd0, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pio_irq_servicer.md
Name: pio_irq_servicer

Overview:
- Avalon-MM master that owns and sequences one edge-capturing PIO slave: 2-bit address, 1-cycle registered readdata, irq_mask at offset 2, edge_capture at offset 3, write-to-clear.
- Programs the PIO interrupt mask, services the PIO irq by reading and clearing edge_capture, and queues the masked event bitmaps in a small FIFO.
- Downstream logic consumes events through a valid/ready port, so no processor interrupt is needed for button/switch events.

Parameters:
- WIDTH, 5, PIO data width; also event bitmap width.
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- MASK_INIT, {WIDTH{1'b1}}, mask value written to the PIO after reset.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- cfg_mask  in  WIDTH  new irq mask; sampled when cfg_load=1.
- cfg_load  in  1  one-cycle pulse requesting a mask update.
- ovf_clr  in  1  clears the overflow flag.
- m_address  out  2  PIO address.
- m_chipselect  out  1  PIO chipselect.
- m_write_n  out  1  PIO write strobe, active-low.
- m_writedata  out  32  PIO write data.
- m_readdata  in  32  PIO readdata; valid the cycle after the address is presented.
- pio_irq  in  1  PIO irq.
- ev_valid  out  1  FIFO not empty.
- ev_data  out  WIDTH  FIFO head bitmap.
- ev_ready  in  1  consumer accepts the head.
- overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
- ev_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset and clock: reset_n is asynchronous, active-low; all state is in the clk domain.
- Reset values: state=S_MASK, mask_reg=MASK_INIT, mask_pend=0, FIFO empty, overflow=0, ev_valid=0, ev_count=0.
- Bus idle values: m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0.
- Bus outputs are decoded from the state register only. Every bus access lasts exactly 1 cycle.
- FSM:
  - S_MASK: drive cs=1, write_n=0, addr=2, writedata={0, mask_reg}. Clear mask_pend. Next state S_IDLE.
  - S_IDLE: if mask_pend, go to S_MASK (priority); else if pio_irq, go to S_RD; else stay.
  - S_RD: drive cs=1, write_n=1, addr=3. Next state S_CLR.
  - S_CLR: sample cap = m_readdata[WIDTH-1:0] & mask_reg. Drive cs=1, write_n=0, addr=3, writedata=32'hFFFFFFFF. Push cap into the FIFO if cap!=0. Next state S_IDLE.
- Service latency: irq high in S_IDLE gives the read 1 cycle later and the clear 2 cycles later. Earliest push lands at the same edge that ends S_CLR, so ev_valid is high 3 cycles after irq is first seen in S_IDLE.
- The PIO updates irq one cycle after the clear, so S_IDLE never re-services a stale irq.
- cfg_load: accepted in any state. mask_reg<=cfg_mask and mask_pend<=1 on the same edge. A second cfg_load before S_MASK runs overwrites mask_reg; only one write is issued. The S_CLR filter uses the mask_reg value current in that cycle.
- FIFO:
  - Push occurs only in S_CLR with cap!=0. Pop occurs when ev_valid && ev_ready.
  - Push when full without a same-cycle pop: entry dropped, overflow<=1. Push when full with a same-cycle pop: accepted, count unchanged.
  - Simultaneous push and pop when empty: the push lands and there is no pop, since ev_valid was 0.
  - Pointers wrap modulo FIFO_DEPTH. ev_data is the head entry, stable while ev_valid && !ev_ready.
- overflow: stays set until ovf_clr. If ovf_clr and a new drop occur in the same cycle, overflow stays 1.
- Loss window: an edge whose PIO detection coincides with the S_CLR cycle is lost, because the PIO clear has priority. This is accepted.
- Reset mid-operation: any in-flight access is abandoned and the FIFO is flushed. After reset release, S_MASK rewrites MASK_INIT.

Test Plan:
- Reset release with MASK_INIT=5'h1F -> first cycle: cs=1, write_n=0, addr=2, writedata=32'h1F; then bus idle, ev_valid=0, overflow=0.
- PIO model edge_capture=5'b00101 with irq=1 -> S_RD addr=3 read, then addr=3 write 32'hFFFFFFFF; ev_data=5'b00101 and ev_valid=1 three cycles after irq seen; ev_count=1.
- cfg_load with cfg_mask=5'b00001 during S_RD -> S_CLR pushes capture 5'b00110 & 5'b00001 = 0, so no push; next cycle S_MASK writes 32'h1.
- ev_ready=0 with 5 irq services of 5'b00001..5'b00101 and FIFO_DEPTH=4 -> ev_count=4, overflow=1, head=5'b00001. Raise ev_ready -> pops 1,2,3,4 in order; 5 is lost.
- FIFO full, push and pop in the same cycle -> ev_count stays 4, overflow unchanged, new entry appears at the tail.
- reset_n asserted in S_CLR with 2 entries queued -> ev_valid=0 and ev_count=0 immediately; after release the S_MASK write repeats.
